// File: rtl/axilite_bk_pkg.sv
// Shared types and helpers for the AXI-Lite backend register bank.
// Read FSM states, decode-error data and byte-strobe merge.
package axilite_bk_pkg;

    typedef enum logic [1:0] {
        RD_IDLE = 2'd0,
        RD_WAIT = 2'd1,
        RD_DONE = 2'd2
    } rd_state_e;

    localparam logic [31:0] DECERR_DATA = 32'hDEAD_BEEF;

    function automatic logic [31:0] bk_merge_strb(
        input logic [31:0] old_v,
        input logic [31:0] new_v,
        input logic [3:0]  strb
    );
        logic [31:0] r;
        for (int k = 0; k < 4; k++) begin
            r[8*k +: 8] = strb[k] ? new_v[8*k +: 8] : old_v[8*k +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/axilite_bk_rdpipe.sv
// Read pipeline: fixed-latency FSM, holding register, overrun detect.
// A request is accepted only in RD_IDLE; bk_rdata is zero unless done.
module axilite_bk_rdpipe
    import axilite_bk_pkg::*;
#(
    parameter int RD_LAT = 2
) (
    input  logic        axi_aclk,
    input  logic        axi_aresetn,
    input  logic        rstart,
    input  logic [31:0] cap_data,
    output logic [31:0] rdata,
    output logic        rdone,
    output logic        overrun
);

    rd_state_e   state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] hold_q, hold_d;

    // State, latency counter and captured read data.
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            state_q <= RD_IDLE;
            cnt_q   <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
        end
    end

    // Next-state, capture and completion outputs.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hold_d  = hold_q;
        rdone   = 1'b0;
        rdata   = '0;
        overrun = 1'b0;
        unique case (state_q)
            RD_IDLE: begin
                if (rstart) begin
                    hold_d = cap_data;
                    if (RD_LAT == 1) begin
                        state_d = RD_DONE;
                    end else begin
                        state_d = RD_WAIT;
                        cnt_d   = 4'(RD_LAT - 1);
                    end
                end
            end
            RD_WAIT: begin
                overrun = rstart;
                if (cnt_q <= 4'd1) begin
                    state_d = RD_DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RD_DONE: begin
                overrun = rstart;
                rdone   = 1'b1;
                rdata   = hold_q;
                state_d = RD_IDLE;
            end
            default: state_d = RD_IDLE;
        endcase
    end

endmodule

// File: rtl/axilite_bk_regfile.sv
// Register bank behind the AXI-Lite backend: decode, RW array,
// RO status mux, write/read forwarding and sticky error flags.
module axilite_bk_regfile
    import axilite_bk_pkg::*;
#(
    parameter int          NUM_REGS  = 16,
    parameter int          NUM_RO    = 4,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          RD_LAT    = 2,
    parameter logic [31:0] RST_VAL   = 32'h0000_0000
) (
    input  logic                       axi_aclk,
    input  logic                       axi_aresetn,
    input  logic                       bk_wstart,
    input  logic [31:0]                bk_waddr,
    input  logic [31:0]                bk_wdata,
    input  logic [3:0]                 bk_wstrb,
    input  logic                       bk_rstart,
    input  logic [31:0]                bk_raddr,
    output logic [31:0]                bk_rdata,
    output logic                       bk_rdone,
    output logic [NUM_REGS*32-1:0]     reg_q,
    output logic [NUM_REGS-1:0]        reg_wr_pulse,
    input  logic [((NUM_RO > 0) ? NUM_RO : 1)*32-1:0] sts_i,
    output logic [1:0]                 err_o,
    input  logic                       err_clr
);

    localparam int          IW     = $clog2(NUM_REGS);
    localparam int          NUM_RW = NUM_REGS - NUM_RO;
    localparam logic [31:0] MASK   = ~32'(NUM_REGS * 4 - 1);

    logic [31:0]   regs [NUM_REGS];
    logic [IW-1:0] w_idx, r_idx;
    logic          w_hit, r_hit, w_ok, w_err;
    logic [31:0]   sts_word, cap_data;
    logic          overrun;

    assign w_hit = (bk_waddr & MASK) == BASE_ADDR;
    assign r_hit = (bk_raddr & MASK) == BASE_ADDR;
    assign w_idx = bk_waddr[2 +: IW];
    assign r_idx = bk_raddr[2 +: IW];
    assign w_ok  = bk_wstart && w_hit && (int'(w_idx) < NUM_RW);
    assign w_err = bk_wstart && !w_ok;

    // RW storage; RO slots stay zero so reg_q reports 0 there.
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= (i < NUM_RW) ? RST_VAL : '0;
            end
        end else if (w_ok) begin
            regs[w_idx] <= bk_merge_strb(regs[w_idx], bk_wdata, bk_wstrb);
        end
    end

    // One-cycle strobe marking each committed write.
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            reg_wr_pulse <= '0;
        end else begin
            reg_wr_pulse <= '0;
            if (w_ok) begin
                reg_wr_pulse[w_idx] <= 1'b1;
            end
        end
    end

    // Sticky errors; a new error beats a simultaneous clear.
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            err_o <= '0;
        end else begin
            err_o <= (err_o & {2{~err_clr}}) | {overrun, w_err};
        end
    end

    // Read capture source: miss, RO status, or RW with write forwarding.
    always_comb begin
        sts_word = '0;
        for (int j = 0; j < NUM_RO; j++) begin
            if (int'(r_idx) == NUM_RW + j) begin
                sts_word = sts_i[32*j +: 32];
            end
        end
        unique case (1'b1)
            !r_hit:
                cap_data = DECERR_DATA;
            int'(r_idx) >= NUM_RW:
                cap_data = sts_word;
            w_ok && (w_idx == r_idx):
                cap_data = bk_merge_strb(regs[r_idx], bk_wdata, bk_wstrb);
            default:
                cap_data = regs[r_idx];
        endcase
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_q
        assign reg_q[32*g +: 32] = regs[g];
    end

    axilite_bk_rdpipe #(
        .RD_LAT (RD_LAT)
    ) u_rdpipe (
        .axi_aclk    (axi_aclk),
        .axi_aresetn (axi_aresetn),
        .rstart      (bk_rstart),
        .cap_data    (cap_data),
        .rdata       (bk_rdata),
        .rdone       (bk_rdone),
        .overrun     (overrun)
    );

endmodule

// File: tb/tb_axilite_bk_regfile.sv
// Self-checking bench for axilite_bk_regfile.
// Scenario tasks against a behavioural register-bank model.
module tb_axilite_bk_regfile;

    localparam int NR  = 16;
    localparam int NRO = 4;
    localparam int NRW = NR - NRO;
    localparam int LAT = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          bk_wstart, bk_rstart, err_clr;
    logic [31:0]   bk_waddr, bk_wdata, bk_raddr;
    logic [3:0]    bk_wstrb;
    logic [31:0]   bk_rdata;
    logic          bk_rdone;
    logic [NR*32-1:0]  reg_q;
    logic [NR-1:0]     reg_wr_pulse;
    logic [NRO*32-1:0] sts_i;
    logic [1:0]        err_o;

    logic [31:0] mdl [NR];
    logic [1:0]  merr;
    int total = 0;
    int bad = 0;

    axilite_bk_regfile #(
        .NUM_REGS  (NR),
        .NUM_RO    (NRO),
        .BASE_ADDR (32'h0),
        .RD_LAT    (LAT),
        .RST_VAL   (32'h0)
    ) dut (
        .axi_aclk     (clk),
        .axi_aresetn  (rst_n),
        .bk_wstart    (bk_wstart),
        .bk_waddr     (bk_waddr),
        .bk_wdata     (bk_wdata),
        .bk_wstrb     (bk_wstrb),
        .bk_rstart    (bk_rstart),
        .bk_raddr     (bk_raddr),
        .bk_rdata     (bk_rdata),
        .bk_rdone     (bk_rdone),
        .reg_q        (reg_q),
        .reg_wr_pulse (reg_wr_pulse),
        .sts_i        (sts_i),
        .err_o        (err_o),
        .err_clr      (err_clr)
    );

    always #5 clk = ~clk;

    function automatic logic [NR*32-1:0] exp_q();
        logic [NR*32-1:0] v;
        for (int i = 0; i < NR; i++) begin
            v[32*i +: 32] = (i < NRW) ? mdl[i] : 32'h0;
        end
        return v;
    endfunction

    function automatic bit in_win(input logic [31:0] a);
        return a < 32'(NR * 4);
    endfunction

    function automatic logic [31:0] exp_read(input logic [31:0] a);
        int ix;
        ix = int'(a[5:2]);
        if (!in_win(a)) return 32'hDEAD_BEEF;
        if (ix >= NRW) return sts_i[32*(ix-NRW) +: 32];
        return mdl[ix];
    endfunction

    task automatic mdl_reset();
        for (int i = 0; i < NR; i++) mdl[i] = 32'h0;
        merr = 2'b00;
    endtask

    task automatic mdl_write(input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] s, output logic [NR-1:0] pulse);
        int ix;
        ix = int'(a[5:2]);
        pulse = '0;
        if (in_win(a) && ix < NRW) begin
            for (int k = 0; k < 4; k++)
                if (s[k]) mdl[ix][8*k +: 8] = d[8*k +: 8];
            pulse[ix] = 1'b1;
        end else begin
            merr[0] = 1'b1;
        end
    endtask

    task automatic run_write(input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] s, input string nm);
        logic [NR-1:0] p;
        @(negedge clk);
        bk_wstart = 1'b1; bk_waddr = a; bk_wdata = d; bk_wstrb = s;
        mdl_write(a, d, s, p);
        @(negedge clk);
        bk_wstart = 1'b0;
        total++;
        if (reg_q !== exp_q()) begin
            bad++;
            $display("FAIL %s reg_q got=%h want=%h", nm, reg_q, exp_q());
        end
        total++;
        if (reg_wr_pulse !== p || err_o !== merr) begin
            bad++;
            $display("FAIL %s pulse/err got=%h/%b want=%h/%b",
                     nm, reg_wr_pulse, err_o, p, merr);
        end
        @(negedge clk);
        total++;
        if (reg_wr_pulse !== '0) begin
            bad++;
            $display("FAIL %s pulse_clear got=%h want=0", nm, reg_wr_pulse);
        end
    endtask

    task automatic run_read(input logic [31:0] a, input logic [31:0] e,
                            input string nm);
        bit seen, zbad;
        seen = 0; zbad = 0;
        @(negedge clk);
        bk_rstart = 1'b1; bk_raddr = a;
        @(negedge clk);
        bk_rstart = 1'b0;
        for (int k = 1; k <= 20 && !seen; k++) begin
            if (bk_rdone) begin
                seen = 1;
                total++;
                if (k != LAT || bk_rdata !== e) begin
                    bad++;
                    $display("FAIL %s lat/data got=%0d/%h want=%0d/%h",
                             nm, k, bk_rdata, LAT, e);
                end
            end else begin
                if (bk_rdata !== 32'h0) zbad = 1;
                @(negedge clk);
            end
        end
        total++;
        if (!seen || zbad) begin
            bad++;
            $display("FAIL %s done/idle_zero got=%0d/%0d want=1/0", nm, seen, zbad);
        end
    endtask

    task automatic clear_err();
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        merr = 2'b00;
        total++;
        if (err_o !== 2'b00) begin
            bad++;
            $display("FAIL err_clr got=%b want=00", err_o);
        end
    endtask

    task automatic test_reset();
        total++;
        if (reg_q !== exp_q() || reg_wr_pulse !== '0 || err_o !== 2'b00 ||
            bk_rdone !== 1'b0 || bk_rdata !== 32'h0) begin
            bad++;
            $display("FAIL reset got q=%h p=%h e=%b d=%b r=%h want zeros",
                     reg_q, reg_wr_pulse, err_o, bk_rdone, bk_rdata);
        end
    endtask

    task automatic test_basic();
        run_write(32'h08, 32'h1234_5678, 4'hF, "basic_wr");
        run_read(32'h08, 32'h1234_5678, "basic_rd");
    endtask

    task automatic test_strobe();
        run_write(32'h04, 32'hAABB_CCDD, 4'b0101, "strobe_wr");
        total++;
        if (reg_q[63:32] !== 32'h00BB_00DD) begin
            bad++;
            $display("FAIL strobe_val got=%h want=00bb00dd", reg_q[63:32]);
        end
        run_read(32'h06, 32'h00BB_00DD, "strobe_rd_lowbits");
    endtask

    task automatic test_ro();
        sts_i[127:96] = 32'hCAFE_0001;
        run_read(32'h3C, 32'hCAFE_0001, "ro_rd");
        run_write(32'h3C, 32'h5555_5555, 4'hF, "ro_wr");
        clear_err();
    endtask

    task automatic test_miss_overrun();
        bit late;
        @(negedge clk);
        bk_rstart = 1'b1; bk_raddr = 32'h100;
        @(negedge clk);
        bk_raddr = 32'h08;
        @(negedge clk);
        bk_rstart = 1'b0;
        total++;
        if (bk_rdone !== 1'b1 || bk_rdata !== 32'hDEAD_BEEF) begin
            bad++;
            $display("FAIL miss_rd got=%b/%h want=1/deadbeef", bk_rdone, bk_rdata);
        end
        late = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (bk_rdone) late = 1;
        end
        total++;
        if (late || err_o !== 2'b10) begin
            bad++;
            $display("FAIL overrun got=%0d/%b want=0/10", late, err_o);
        end
        clear_err();
    endtask

    task automatic test_fwd();
        logic [NR-1:0] p;
        run_write(32'h08, 32'h1111_1111, 4'hF, "fwd_pre");
        @(negedge clk);
        bk_wstart = 1'b1; bk_waddr = 32'h08;
        bk_wdata = 32'hFFFF_0000; bk_wstrb = 4'hC;
        bk_rstart = 1'b1; bk_raddr = 32'h08;
        mdl_write(32'h08, 32'hFFFF_0000, 4'hC, p);
        @(negedge clk);
        bk_wstart = 1'b0; bk_rstart = 1'b0;
        @(negedge clk);
        total++;
        if (bk_rdone !== 1'b1 || bk_rdata !== 32'hFFFF_1111) begin
            bad++;
            $display("FAIL fwd_rd got=%b/%h want=1/ffff1111", bk_rdone, bk_rdata);
        end
    endtask

    task automatic test_wait_write();
        logic [31:0] old_v;
        logic [NR-1:0] p;
        old_v = mdl[3];
        @(negedge clk);
        bk_rstart = 1'b1; bk_raddr = 32'h0C;
        @(negedge clk);
        bk_rstart = 1'b0;
        bk_wstart = 1'b1; bk_waddr = 32'h0C;
        bk_wdata = ~old_v; bk_wstrb = 4'hF;
        mdl_write(32'h0C, ~old_v, 4'hF, p);
        @(negedge clk);
        bk_wstart = 1'b0;
        total++;
        if (bk_rdone !== 1'b1 || bk_rdata !== old_v) begin
            bad++;
            $display("FAIL wait_wr got=%b/%h want=1/%h", bk_rdone, bk_rdata, old_v);
        end
    endtask

    task automatic test_clr_vs_set();
        logic [NR-1:0] p;
        @(negedge clk);
        err_clr = 1'b1; bk_wstart = 1'b1;
        bk_waddr = 32'h200; bk_wdata = 32'h1; bk_wstrb = 4'hF;
        mdl_write(32'h200, 32'h1, 4'hF, p);
        @(negedge clk);
        err_clr = 1'b0; bk_wstart = 1'b0;
        total++;
        if (err_o !== 2'b01) begin
            bad++;
            $display("FAIL clr_vs_set got=%b want=01", err_o);
        end
    endtask

    task automatic test_reset_mid();
        bit spur;
        spur = 0;
        @(negedge clk);
        bk_rstart = 1'b1; bk_raddr = 32'h08;
        @(negedge clk);
        bk_rstart = 1'b0;
        rst_n = 1'b0;
        mdl_reset();
        for (int k = 0; k < 4; k++) begin
            #1;
            if (bk_rdone) spur = 1;
            @(negedge clk);
        end
        total++;
        if (spur || reg_q !== exp_q() || err_o !== 2'b00) begin
            bad++;
            $display("FAIL reset_mid got=%0d/%b want=0/00", spur, err_o);
        end
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (bk_rdone) spur = 1;
        end
        total++;
        if (spur) begin
            bad++;
            $display("FAIL reset_mid_late_done got=1 want=0");
        end
        run_read(32'h08, 32'h0, "reset_mid_next");
    endtask

    task automatic test_random();
        logic [31:0] a;
        for (int n = 0; n < 40; n++) begin
            sts_i = {$urandom, $urandom, $urandom, $urandom};
            if ($urandom_range(0, 4) == 0)
                a = $urandom | 32'h40;
            else
                a = {26'h0, 4'($urandom_range(0, NR-1)), 2'($urandom)};
            if ($urandom_range(0, 1) == 0)
                run_write(a, $urandom, 4'($urandom), "rand_wr");
            else
                run_read(a, exp_read(a), "rand_rd");
        end
        clear_err();
    endtask

    initial begin
        rst_n = 1'b0;
        bk_wstart = 1'b0; bk_rstart = 1'b0; err_clr = 1'b0;
        bk_waddr = '0; bk_wdata = '0; bk_wstrb = '0; bk_raddr = '0;
        sts_i = '0;
        mdl_reset();
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        test_basic();
        test_strobe();
        test_ro();
        test_miss_overrun();
        test_fwd();
        test_wait_write();
        test_clr_vs_set();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
